// File: rtl/wave_gen_pkg.sv
// Shared constants and encodings for the waveform generator and the downstream shifter stage.
package wave_gen_pkg;

    localparam int unsigned PHASE_W  = 8;
    localparam int unsigned SAMPLE_W = 16;

    typedef enum logic [1:0] {
        WAVE_SQUARE = 2'b00,
        WAVE_SAW    = 2'b01,
        WAVE_TRI    = 2'b10,
        WAVE_STAIR  = 2'b11
    } wave_sel_e;

endpackage

// File: rtl/wave_shape.sv
// Combinational phase-to-sample mapping for the four supported waveforms.
module wave_shape
    import wave_gen_pkg::*;
(
    input  logic [1:0]          sel,
    input  logic [7:0]          phase,
    output logic [SAMPLE_W-1:0] sample
);

    logic [6:0] tri_t;

    always_comb begin
        // Second half folds back down: 127 - p[6:0] is the bitwise inverse.
        tri_t  = phase[7] ? ~phase[6:0] : phase[6:0];
        sample = '0;
        unique case (sel)
            WAVE_SQUARE: sample = {SAMPLE_W{~phase[7]}};
            WAVE_SAW:    sample = {phase, phase};
            WAVE_TRI:    sample = {tri_t, tri_t, tri_t[6:5]};
            WAVE_STAIR:  sample = {{5{phase[7:5]}}, phase[7]};
            default:     sample = '0;
        endcase
    end

endmodule

// File: rtl/wave_gen.sv
// Divided-rate waveform generator: one registered sample per freq+1 enabled clocks,
// with the waveform selection only changing on a period boundary.
module wave_gen #(
    parameter int unsigned PHASE_W = wave_gen_pkg::PHASE_W,
    parameter int unsigned DIV_W   = 8
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              en,
    input  logic                              sync,
    input  logic [1:0]                        wave_sel,
    input  logic [DIV_W-1:0]                  freq,
    output logic [wave_gen_pkg::SAMPLE_W-1:0] outwave,
    output logic                              valid,
    output logic                              period_end
);

    localparam logic [PHASE_W-1:0] PhaseMax = '1;

    logic [DIV_W-1:0]                  div_cnt, div_cnt_d;
    logic [PHASE_W-1:0]                phase, phase_d;
    logic [DIV_W-1:0]                  freq_reg, freq_reg_d;
    logic [1:0]                        sel_reg, sel_reg_d;
    logic [wave_gen_pkg::SAMPLE_W-1:0] outwave_d;
    logic                              valid_d;
    logic                              period_end_d;

    logic                              tick;
    logic                              phase_last;
    logic [wave_gen_pkg::SAMPLE_W-1:0] shape_sample;

    // Only the top 8 phase bits shape the output.
    wave_shape u_wave_shape (
        .sel    (sel_reg),
        .phase  (phase[PHASE_W-1 -: 8]),
        .sample (shape_sample)
    );

    assign tick       = en && !sync && (div_cnt == freq_reg);
    assign phase_last = (phase == PhaseMax);

    always_comb begin
        div_cnt_d    = div_cnt;
        phase_d      = phase;
        freq_reg_d   = freq_reg;
        sel_reg_d    = sel_reg;
        outwave_d    = outwave;
        valid_d      = 1'b0;
        period_end_d = 1'b0;

        if (sync) begin
            div_cnt_d  = '0;
            phase_d    = '0;
            freq_reg_d = freq;
            sel_reg_d  = wave_sel;
        end else if (!en) begin
            div_cnt_d  = '0;
            freq_reg_d = freq;
            sel_reg_d  = wave_sel;
        end else if (tick) begin
            div_cnt_d    = '0;
            freq_reg_d   = freq;
            outwave_d    = shape_sample;
            valid_d      = 1'b1;
            phase_d      = phase + 1'b1;
            period_end_d = phase_last;
            // Waveform switches only at the period boundary.
            if (phase_last) begin
                sel_reg_d = wave_sel;
            end
        end else begin
            div_cnt_d = div_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            div_cnt    <= '0;
            phase      <= '0;
            freq_reg   <= '0;
            sel_reg    <= '0;
            outwave    <= '0;
            valid      <= 1'b0;
            period_end <= 1'b0;
        end else begin
            div_cnt    <= div_cnt_d;
            phase      <= phase_d;
            freq_reg   <= freq_reg_d;
            sel_reg    <= sel_reg_d;
            outwave    <= outwave_d;
            valid      <= valid_d;
            period_end <= period_end_d;
        end
    end

endmodule

// File: tb/tb_wave_gen.sv
// Directed self-checking bench for wave_gen: reset, sawtooth, square, triangle,
// mid-period select change and sync restart.
module tb_wave_gen;

    logic        clk;
    logic        rst_n;
    logic        en;
    logic        sync;
    logic [1:0]  wave_sel;
    logic [7:0]  freq;
    logic [15:0] outwave;
    logic        valid;
    logic        period_end;

    int compared;
    int mismatched;

    wave_gen #(
        .PHASE_W (8),
        .DIV_W   (8)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .sync       (sync),
        .wave_sel   (wave_sel),
        .freq       (freq),
        .outwave    (outwave),
        .valid      (valid),
        .period_end (period_end)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        logic [7:0] kb;
        compared   = 0;
        mismatched = 0;
        rst_n      = 1'b0;
        en         = 1'b0;
        sync       = 1'b0;
        wave_sel   = 2'b01;
        freq       = 8'd3;

        // Power-on reset
        step();
        step();
        chk("rst_outwave", outwave, 32'h0);
        chk("rst_valid", valid, 0);
        chk("rst_pend", period_end, 0);

        // Sawtooth, freq=3: en low one clock, then high
        rst_n = 1'b1;
        step();
        chk("saw_enlow_valid", valid, 0);
        en = 1'b1;
        repeat (3) begin
            step();
            chk("saw_lat_valid", valid, 0);
        end
        step();
        chk("saw_first_valid", valid, 1);
        chk("saw_first_out", outwave, 32'h0000);
        chk("saw_first_pend", period_end, 0);
        for (int k = 1; k < 256; k++) begin
            kb = k[7:0];
            repeat (3) begin
                step();
                chk($sformatf("saw_gap_%0d", k), valid, 0);
            end
            step();
            chk($sformatf("saw_valid_%0d", k), valid, 1);
            chk($sformatf("saw_out_%0d", k), outwave, {16'h0, kb, kb});
            chk($sformatf("saw_pend_%0d", k), period_end, (k == 255) ? 1 : 0);
        end
        repeat (3) step();
        step();
        chk("saw_wrap_valid", valid, 1);
        chk("saw_wrap_out", outwave, 32'h0000);
        chk("saw_wrap_pend", period_end, 0);

        // Mid-run reset held for two clocks, then square at freq=0
        step();
        rst_n = 1'b0;
        step();
        chk("mrst_outwave", outwave, 32'h0);
        chk("mrst_valid", valid, 0);
        chk("mrst_pend", period_end, 0);
        wave_sel = 2'b00;
        freq     = 8'd0;
        step();
        chk("mrst2_outwave", outwave, 32'h0);
        chk("mrst2_valid", valid, 0);
        rst_n = 1'b1;
        step();
        chk("sq_valid_0", valid, 1);
        chk("sq_out_0", outwave, 32'hFFFF);
        chk("sq_pend_0", period_end, 0);
        for (int k = 1; k < 256; k++) begin
            step();
            chk($sformatf("sq_valid_%0d", k), valid, 1);
            chk($sformatf("sq_out_%0d", k), outwave, (k < 128) ? 32'hFFFF : 32'h0000);
            chk($sformatf("sq_pend_%0d", k), period_end, (k == 255) ? 1 : 0);
        end

        // Triangle, freq=1, loaded while disabled
        en       = 1'b0;
        wave_sel = 2'b10;
        freq     = 8'd1;
        step();
        chk("tri_dis_valid", valid, 0);
        chk("tri_dis_hold", outwave, 32'h0000);
        en = 1'b1;
        for (int k = 0; k < 256; k++) begin
            step();
            chk($sformatf("tri_gap_%0d", k), valid, 0);
            step();
            chk($sformatf("tri_valid_%0d", k), valid, 1);
            if (k == 0)   chk("tri_out_0", outwave, 32'h0000);
            if (k == 64)  chk("tri_out_64", outwave, 32'h8102);
            if (k == 127) chk("tri_out_127", outwave, 32'hFFFF);
            if (k == 128) chk("tri_out_128", outwave, 32'hFFFF);
            if (k == 255) chk("tri_out_255", outwave, 32'h0000);
        end

        // Select change mid-period: sawtooth must finish the period
        en       = 1'b0;
        freq     = 8'd0;
        wave_sel = 2'b01;
        step();
        en = 1'b1;
        for (int k = 0; k < 256; k++) begin
            kb = k[7:0];
            step();
            chk($sformatf("sel_valid_%0d", k), valid, 1);
            chk($sformatf("sel_out_%0d", k), outwave, {16'h0, kb, kb});
            if (k == 10) wave_sel = 2'b00;
        end
        step();
        chk("sel_next_valid", valid, 1);
        chk("sel_next_out", outwave, 32'hFFFF);

        // Sync on a would-be tick edge, freq=2, sawtooth
        en       = 1'b0;
        freq     = 8'd2;
        wave_sel = 2'b01;
        step();
        chk("sync_dis_valid", valid, 0);
        chk("sync_dis_hold", outwave, 32'hFFFF);
        en = 1'b1;
        step();
        chk("sync_a1", valid, 0);
        step();
        chk("sync_a2", valid, 0);
        step();
        chk("sync_a3_valid", valid, 1);
        chk("sync_a3_out", outwave, 32'h0101);
        step();
        chk("sync_b1", valid, 0);
        step();
        chk("sync_b2", valid, 0);
        sync = 1'b1;
        step();
        chk("sync_edge_valid", valid, 0);
        chk("sync_edge_out", outwave, 32'h0101);
        chk("sync_edge_pend", period_end, 0);
        sync = 1'b0;
        step();
        chk("sync_c1", valid, 0);
        step();
        chk("sync_c2", valid, 0);
        step();
        chk("sync_c3_valid", valid, 1);
        chk("sync_c3_out", outwave, 32'h0000);
        chk("sync_c3_pend", period_end, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/wave_gen.md
WAVE_GEN -- requirements
Module: wave_gen

Interface
REQ-001 Parameter PHASE_W, default 8: phase counter width, 256 samples per period.
REQ-002 Parameter DIV_W, default 8: width of the sample-rate divider.
REQ-003 clk  input  1  sole clock; all state updates on the rising edge.
REQ-004 rst_n  input  1  synchronous, active-low reset.
REQ-005 en  input  1  generator enable.
REQ-006 sync  input  1  phase restart request, active high.
REQ-007 wave_sel  input  2  waveform select: 00 square, 01 sawtooth, 10 triangle, 11 staircase.
REQ-008 freq  input  DIV_W  divider value; one sample every freq+1 enabled clocks.
REQ-009 outwave  output  16  registered unsigned sample; this is the data input of the downstream amplitude shifter.
REQ-010 valid  output  1  one-cycle pulse marking a new outwave value.
REQ-011 period_end  output  1  one-cycle pulse, coincident with valid, on the phase-255 sample.

Function
REQ-012 Internal registers SHALL be div_cnt (DIV_W), phase (PHASE_W), freq_reg (DIV_W) and sel_reg (2).
REQ-013 tick SHALL be defined as en=1, sync=0 and div_cnt==freq_reg.
REQ-014 On an enabled non-tick edge, div_cnt SHALL increment and all other state SHALL hold.
REQ-015 On a tick edge, the block SHALL update as follows:
- div_cnt <= 0.
- freq_reg <= freq.
- outwave <= shape(sel_reg, phase), using phase before increment.
- valid <= 1.
- phase <= phase+1, wrapping 255->0.
REQ-016 period_end SHALL be 1 on the tick edge where phase==255, and 0 otherwise.
REQ-017 sel_reg SHALL load wave_sel only on the phase==255 tick edge or while en=0, so the waveform never changes mid-period.
REQ-018 While en=0, the block SHALL update as follows:
- div_cnt <= 0.
- freq_reg <= freq.
- sel_reg <= wave_sel.
- phase and outwave hold.
- valid and period_end are 0.
REQ-019 sync=1 SHALL override tick and set phase to 0, div_cnt to 0, valid to 0 and period_end to 0.
REQ-020 Under sync=1, outwave SHALL hold, and freq_reg and sel_reg SHALL load as in REQ-018.
REQ-021 Latency: the first valid after en rises SHALL occur on the (freq_reg+1)-th enabled edge.
REQ-022 Steady-state valid spacing SHALL be exactly freq+1 clocks, including freq=0, which gives valid every clock.
REQ-023 shape(sel, p) SHALL be combinational, using t = p[7] ? (127 - p[6:0]) : p[6:0], as follows:
- square: p[7]==0 gives 16'hFFFF, else 16'h0000.
- sawtooth: {p, p}.
- triangle: {t, t, t[6:5]}, giving 0x0000 at t=0 and 0xFFFF at t=127.
- staircase: {p[7:5] replicated 5 times, p[7]}, giving 8 levels from 0x0000 to 0xFFFF.
REQ-024 valid SHALL carry no backpressure; the consumer samples outwave whenever valid=1, and outwave stays stable until the next valid.

Reset
REQ-025 With rst_n=0 at an edge, all of the following SHALL be 0: outwave, valid, period_end, phase, div_cnt, freq_reg and sel_reg.
REQ-026 Reset SHALL have priority over sync, en and tick, and SHALL take effect mid-period, with no sample emitted on that edge.

Structure
REQ-027 A shared package wave_gen_pkg SHALL hold:
- the wave_sel encodings WAVE_SQUARE, WAVE_SAW, WAVE_TRI and WAVE_STAIR;
- PHASE_W;
- the 16-bit sample width constant, shared with the shifter stage.
REQ-028 shape() SHALL be one combinational sub-module, wave_shape (inputs sel and phase; output sample).
REQ-029 All other logic SHALL sit in wave_gen, with no further hierarchy.

Verification
REQ-030 Reset: rst_n=0 for 2 clocks mid-run -> outwave=0x0000, valid=0 and period_end=0 on the next edge; phase restarts at 0.
REQ-031 Sawtooth with freq=3:
- stimulus: en low 1 clock, then high.
- valid every 4 clocks.
- samples 0x0000, 0x0101, 0x0202, ...
- 256th sample is 0xFFFF with period_end=1, then 0x0000 follows.
REQ-032 Square with freq=0 -> valid every clock; samples 0-127 are 0xFFFF and samples 128-255 are 0x0000.
REQ-033 Triangle with freq=1 -> samples at phase 0, 127, 128 and 255 are 0x0000, 0xFFFF, 0xFFFF and 0x0000; valid every 2 clocks.
REQ-034 wave_sel changed from 01 to 00 at phase 10 -> sawtooth continues through phase 255; the phase-0 sample of the next period is 0xFFFF (square).
REQ-035 sync=1 on a would-be tick edge -> no valid on that edge, outwave unchanged; the next sample comes freq+1 clocks later as shape(sel_reg, 0).
